reg_writeback: RTL

Writer side of the integer register file port. Accepts completed results from the execute and load units over a valid/ready handshake, buffers them in a small in-order FIFO, and drives the register file's `RegWrite`/`rd`/`rd_write_data` write port one result per cycle. A per-register pending-write scoreboard gives decode busy flags for `rs1`/`rs2`, and optionally forwards buffered results.

---
 rtl/reg_writeback.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/reg_writeback.sv
// Register file write-back port: in-order result FIFO, per-register pending-write
// scoreboard and busy lookup. Define WB_FWD_EN to add forwarding from buffered results.
module reg_writeback #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic [4:0]      res_rd,
  input  logic [XLEN-1:0] res_data,
  output logic            RegWrite,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_write_data,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
`ifdef WB_FWD_EN
  output logic            rs1_fwd_valid,
  output logic            rs2_fwd_valid,
  output logic [XLEN-1:0] rs1_fwd_data,
  output logic [XLEN-1:0] rs2_fwd_data,
`endif
  output logic            rs1_busy,
  output logic            rs2_busy
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PTRW = AW + 1;
  localparam int unsigned PW   = $clog2(DEPTH + 1);

  logic [4:0]      r_mem_rd   [DEPTH];
  logic [XLEN-1:0] r_mem_data [DEPTH];
  logic [PTRW-1:0] r_wptr;
  logic [PTRW-1:0] r_rptr;
  logic [PW-1:0]   r_pend     [32];

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [4:0]      w_head_rd;
  logic [XLEN-1:0] w_head_data;
  logic            w_inc;
  logic            w_dec;

  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push      = res_valid && !w_full;
  assign w_pop       = !w_empty;
  assign w_head_rd   = r_mem_rd[r_rptr[AW-1:0]];
  assign w_head_data = r_mem_data[r_rptr[AW-1:0]];

  // Head of the FIFO drives the register file write port directly.
  assign RegWrite      = !w_empty && (w_head_rd != 5'd0);
  assign rd            = w_empty ? 5'd0 : w_head_rd;
  assign rd_write_data = w_empty ? '0 : w_head_data;
  assign res_ready     = !w_full;
  assign issue_ready   = (issue_rd == 5'd0) || (r_pend[issue_rd] != PW'(DEPTH));

  assign w_inc = issue_valid && issue_ready && (issue_rd != 5'd0);
  assign w_dec = w_pop && (w_head_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr[AW-1:0]]   <= res_rd;
      r_mem_data[r_wptr[AW-1:0]] <= res_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTRW'(1);
      if (w_pop)  r_rptr <= r_rptr + PTRW'(1);
    end
  end

  // Same-register increment and decrement cancel; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_inc && (issue_rd == 5'(i)) && !(w_dec && (w_head_rd == 5'(i)))) begin
          r_pend[i] <= r_pend[i] + PW'(1);
        end else if (w_dec && (w_head_rd == 5'(i)) && !(w_inc && (issue_rd == 5'(i)))
                     && (r_pend[i] != '0)) begin
          r_pend[i] <= r_pend[i] - PW'(1);
        end
      end
    end
  end

`ifdef WB_FWD_EN
  logic [PTRW-1:0] w_count;
  logic [AW-1:0]   w_idx;
  logic [PW-1:0]   w_cnt1;
  logic [PW-1:0]   w_cnt2;
  logic [XLEN-1:0] w_fdat1;
  logic [XLEN-1:0] w_fdat2;
  logic            w_hit1;
  logic            w_hit2;

  assign w_count = r_wptr - r_rptr;

  // Scan oldest to youngest so the last match is the youngest buffered value.
  always_comb begin
    w_idx   = '0;
    w_cnt1  = '0;
    w_cnt2  = '0;
    w_fdat1 = '0;
    w_fdat2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rptr[AW-1:0] + AW'(k);
      if (PTRW'(k) < w_count) begin
        if (r_mem_rd[w_idx] == rs1) begin
          w_cnt1  = w_cnt1 + PW'(1);
          w_fdat1 = r_mem_data[w_idx];
        end
        if (r_mem_rd[w_idx] == rs2) begin
          w_cnt2  = w_cnt2 + PW'(1);
          w_fdat2 = r_mem_data[w_idx];
        end
      end
    end
  end

  assign w_hit1 = (rs1 != 5'd0) && (w_cnt1 != '0) && (w_cnt1 == r_pend[rs1]);
  assign w_hit2 = (rs2 != 5'd0) && (w_cnt2 != '0) && (w_cnt2 == r_pend[rs2]);

  assign rs1_fwd_valid = w_hit1;
  assign rs2_fwd_valid = w_hit2;
  assign rs1_fwd_data  = w_hit1 ? w_fdat1 : '0;
  assign rs2_fwd_data  = w_hit2 ? w_fdat2 : '0;
  assign rs1_busy      = (r_pend[rs1] != '0) && !w_hit1;
  assign rs2_busy      = (r_pend[rs2] != '0) && !w_hit2;
`else
  assign rs1_busy = (r_pend[rs1] != '0);
  assign rs2_busy = (r_pend[rs2] != '0);
`endif

endmodule
